// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter (fetch=s0, load=s1) sharing one memory read port.
// One outstanding burst at a time, round-robin on contention, sticky burst-length error flag.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,

    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,

    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,

    output logic                  err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     state, state_nxt;
    logic       owner;
    logic       last_grant;
    logic       grant;
    logic       grant_vld;
    logic       beat;
    logic [7:0] beat_cnt;

    assign m_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_arburst = 2'b01;

    // last_grant resets to 1 so s0 wins the first contended grant
    always_comb begin
        grant_vld = s0_arvalid | s1_arvalid;
        if (s0_arvalid && s1_arvalid) grant = ~last_grant;
        else                          grant = s1_arvalid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        beat       = 1'b0;
        case (state)
            IDLE: begin
                // arready is combinational from arvalid, so it must also be gated by reset
                s0_arready = !rst && grant_vld && !grant;
                s1_arready = !rst && grant_vld &&  grant;
                if (grant_vld) state_nxt = ADDR;
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_nxt = DATA;
            end
            DATA: begin
                m_rready  = owner ? s1_rready : s0_rready;
                s0_rvalid = !owner && m_rvalid;
                s1_rvalid =  owner && m_rvalid;
                beat      = m_rvalid && m_rready;
                if (beat && m_rlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s1_rresp = m_rresp;
    assign s0_rlast = m_rlast;
    assign s1_rlast = m_rlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            m_araddr   <= '0;
            m_arlen    <= '0;
            m_arid     <= '0;
            beat_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            if (state == IDLE && grant_vld) begin
                owner    <= grant;
                m_araddr <= grant ? s1_araddr : s0_araddr;
                m_arlen  <= grant ? s1_arlen  : s0_arlen;
                m_arid   <= ID_WIDTH'(grant);
                beat_cnt <= '0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + 8'd1;
                // rlast must coincide exactly with the beat numbered arlen
                if (m_rlast != (beat_cnt == m_arlen)) err <= 1'b1;
                if (m_rlast) last_grant <= owner;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: two random requesters, a random memory slave
// with occasional wrong rlast placement, random resets, checked against a transaction model.
module tb_axi_rd_arbiter;

    localparam int AW = 40;
    localparam int DW = 128;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] s0_araddr, s1_araddr;
    logic [7:0]    s0_arlen, s1_arlen;
    logic          s0_arvalid, s1_arvalid;
    logic          s0_arready, s1_arready;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic [1:0]    s0_rresp, s1_rresp;
    logic          s0_rlast, s1_rlast;
    logic          s0_rvalid, s1_rvalid;
    logic          s0_rready, s1_rready;
    logic [IW-1:0] m_arid;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid, m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast, m_rvalid, m_rready;
    logic          err;

    axi_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid),
        .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid),
        .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model of the arbiter
    bit          busy, ar_pend, owner, last_win, merr;
    logic [AW-1:0] e_addr;
    logic [7:0]  e_len;
    int          beats;

    // Memory slave bookkeeping
    bit sl_act;
    int sl_idx, sl_last;

    task automatic model_reset();
        busy = 0; ar_pend = 0; owner = 0; last_win = 1; merr = 0; beats = 0;
        e_addr = '0; e_len = '0;
        sl_act = 0; sl_idx = 0; sl_last = 0;
    endtask

    task automatic drive();
        s0_arvalid = 1'($urandom_range(0, 1));
        s1_arvalid = 1'($urandom_range(0, 1));
        s0_araddr  = AW'({$urandom(), $urandom()});
        s1_araddr  = AW'({$urandom(), $urandom()});
        s0_arlen   = 8'($urandom_range(0, 3));
        s1_arlen   = 8'($urandom_range(0, 3));
        s0_rready  = ($urandom_range(0, 3) != 0);
        s1_rready  = ($urandom_range(0, 3) != 0);
        m_arready  = ($urandom_range(0, 9) < 6);
        m_rdata    = {$urandom(), $urandom(), $urandom(), $urandom()};
        m_rresp    = 2'($urandom_range(0, 3));
        if (sl_act) begin
            m_rvalid = ($urandom_range(0, 9) < 7);
            m_rlast  = (sl_idx == sl_last);
        end else begin
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
        end
    endtask

    task automatic check_and_step();
        bit win, rr;
        check("arsize", 128'(m_arsize), 128'd4);
        check("arburst", 128'(m_arburst), 128'd1);
        check("err", 128'(err), 128'(merr));
        if (!busy) begin
            win = (s0_arvalid && s1_arvalid) ? !last_win : s1_arvalid;
            check("s0_arready", 128'(s0_arready), 128'(s0_arvalid && !win));
            check("s1_arready", 128'(s1_arready), 128'(s1_arvalid && win));
            check("idle_arvalid", 128'(m_arvalid), 128'd0);
            check("idle_rready", 128'(m_rready), 128'd0);
            check("idle_rvalid", 128'({s1_rvalid, s0_rvalid}), 128'd0);
            if (s0_arvalid || s1_arvalid) begin
                busy = 1; ar_pend = 1; owner = win; beats = 0;
                e_addr = win ? s1_araddr : s0_araddr;
                e_len  = win ? s1_arlen  : s0_arlen;
            end
        end else if (ar_pend) begin
            check("arvalid", 128'(m_arvalid), 128'd1);
            check("araddr", 128'(m_araddr), 128'(e_addr));
            check("arlen", 128'(m_arlen), 128'(e_len));
            check("arid", 128'(m_arid), 128'(owner));
            check("addr_arready", 128'({s1_arready, s0_arready}), 128'd0);
            check("addr_rready", 128'(m_rready), 128'd0);
            check("addr_rvalid", 128'({s1_rvalid, s0_rvalid}), 128'd0);
            if (m_arready) ar_pend = 0;
        end else begin
            rr = owner ? s1_rready : s0_rready;
            check("data_arvalid", 128'(m_arvalid), 128'd0);
            check("data_arready", 128'({s1_arready, s0_arready}), 128'd0);
            check("m_rready", 128'(m_rready), 128'(rr));
            check("s0_rvalid", 128'(s0_rvalid), 128'(!owner && m_rvalid));
            check("s1_rvalid", 128'(s1_rvalid), 128'(owner && m_rvalid));
            if (m_rvalid) begin
                check("rdata", owner ? s1_rdata : s0_rdata, m_rdata);
                check("rresp", 128'(owner ? s1_rresp : s0_rresp), 128'(m_rresp));
                check("rlast", 128'(owner ? s1_rlast : s0_rlast), 128'(m_rlast));
            end
            if (m_rvalid && rr) begin
                if (m_rlast ? (beats != int'(e_len)) : (beats == int'(e_len))) merr = 1;
                beats++;
                if (m_rlast) begin
                    busy = 0;
                    last_win = owner;
                end
            end
        end
        if (m_arvalid && m_arready) begin
            sl_act = 1; sl_idx = 0;
            case ($urandom_range(0, 7))
                0:       sl_last = (m_arlen > 0) ? int'(m_arlen) - 1 : 0;
                1:       sl_last = int'(m_arlen) + 1;
                default: sl_last = int'(m_arlen);
            endcase
        end
        if (m_rvalid && m_rready) begin
            sl_idx++;
            if (m_rlast) sl_act = 0;
        end
    endtask

    task automatic check_reset_state();
        check("rst_arvalid", 128'(m_arvalid), 128'd0);
        check("rst_rready", 128'(m_rready), 128'd0);
        check("rst_arready", 128'({s1_arready, s0_arready}), 128'd0);
        check("rst_rvalid", 128'({s1_rvalid, s0_rvalid}), 128'd0);
        check("rst_err", 128'(err), 128'd0);
        check("rst_araddr", 128'(m_araddr), 128'd0);
        check("rst_arlen", 128'(m_arlen), 128'd0);
        check("rst_arid", 128'(m_arid), 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        drive();
        s0_arvalid = 1'b1;
        s1_arvalid = 1'b1;
        m_rvalid   = 1'b1;
        #3;
        check_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5000; i++) begin
            if (i > 20 && $urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                s0_arvalid = 1'b1;
                s1_arvalid = 1'b1;
                m_rvalid   = 1'b1;
                #1;
                check_reset_state();
                @(posedge clk); #1;
                rst = 1'b0;
                model_reset();
            end
            drive();
            #1;
            check_and_step();
            @(posedge clk); #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 40, address width of all AR channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, data width of all R channels.
REQ-003 SHALL have parameter ID_WIDTH, default 4, width of m_arid.
REQ-004 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports sN_araddr  in  ADDR_WIDTH  requester N read address (N=0 fetch, N=1 load).
REQ-007 SHALL have ports sN_arlen  in  8  requester N burst length minus one.
REQ-008 SHALL have ports sN_arvalid  in  1  requester N request valid.
REQ-009 SHALL have ports sN_arready  out  1  requester N request accepted.
REQ-010 SHALL have ports sN_rdata  out  DATA_WIDTH  routed read data.
REQ-011 SHALL have ports sN_rresp  out  2  routed read response.
REQ-012 SHALL have ports sN_rlast  out  1  routed last beat.
REQ-013 SHALL have ports sN_rvalid  out  1  routed beat valid.
REQ-014 SHALL have ports sN_rready  in  1  requester N beat ready.
REQ-015 SHALL have ports m_arid / m_araddr / m_arlen  out  ID_WIDTH / ADDR_WIDTH / 8  issued AR fields.
REQ-016 SHALL have ports m_arsize / m_arburst  out  3 / 2  constant log2(DATA_WIDTH/8) and 2'b01 (INCR).
REQ-017 SHALL have ports m_arvalid  out  1  and m_arready  in  1  AR handshake to the memory slave.
REQ-018 SHALL have ports m_rdata  in  DATA_WIDTH, m_rresp  in  2, m_rlast  in  1, m_rvalid  in  1, m_rready  out  1  R channel from the slave.
REQ-019 SHALL have port err  out  1  sticky burst-length mismatch flag.

Function
REQ-020 SHALL implement FSM states IDLE, ADDR, DATA; one outstanding transaction at any time.
REQ-021 In IDLE, with any sN_arvalid=1, SHALL grant one requester combinationally and assert only that sN_arready in the same cycle; in every other state, sN_arready SHALL be 0.
REQ-022 When both requests are valid, SHALL grant round-robin: the requester not granted last wins; after reset, s0 wins first.
REQ-023 On grant, SHALL register sN_araddr and sN_arlen, set m_arid={zeros,grant}, load beat counter with 0, and move to ADDR; m_arvalid=1 on the next cycle (1-cycle request-to-AR latency).
REQ-024 In ADDR, SHALL hold m_arvalid and all AR fields stable until m_arready=1, then move to DATA; a requester deasserting arvalid after acceptance SHALL have no effect.
REQ-025 In DATA, SHALL route m_rdata/m_rresp/m_rlast/m_rvalid to the granted requester and drive m_rready=sN_rready of the granted requester; the other requester's rvalid SHALL be 0.
REQ-026 SHALL increment the beat counter on each m_rvalid&m_rready beat.
REQ-027 On a beat with m_rlast=1, SHALL return to IDLE and record the grant for round-robin; a new grant is possible in the following cycle.
REQ-028 SHALL set err=1 if m_rlast=1 on a beat whose counter value differs from the latched arlen, or if the counter reaches arlen without m_rlast=1; err SHALL remain set until reset; the transaction still terminates only on m_rlast.
REQ-029 m_rready and all sN_rvalid SHALL be 0 outside DATA; rresp SHALL be forwarded unmodified.

Reset
REQ-030 On rst=1, asynchronously and regardless of state: FSM=IDLE, m_arvalid=0, m_rready=0, all sN_arready=0, all sN_rvalid=0, err=0, beat counter=0, round-robin favours s0, m_araddr/m_arlen/m_arid=0.
REQ-031 Reset asserted mid-burst SHALL abandon the transaction; after release, the arbiter SHALL accept new requests from IDLE.

Verification
REQ-032 s0 only, araddr=40'h1_0000, arlen=3, slave returns 4 beats -> s0_arready pulses 1 cycle, m_arvalid next cycle with m_arid=0, m_arsize=4; 4 beats on s0_r*; err=0.
REQ-033 s0 and s1 both valid at the same cycle, repeated -> grants s0, s1, s0, s1; m_arid alternates 0,1.
REQ-034 s1 arvalid while s0 burst in DATA -> s1_arready=0 until the cycle after s0 rlast; then granted.
REQ-035 Granted requester holds rready=0 for 3 cycles mid-burst -> m_rready=0 for those cycles; no beat lost or duplicated.
REQ-036 arlen=3 but slave asserts rlast on beat 2 -> err=1, FSM returns to IDLE, err stays 1 until rst.
REQ-037 rst pulsed during DATA beat 2 -> all valids 0 immediately, err=0; next request is served normally with s0 priority.
